// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: the input beat side, the output beat side and the predicate flag.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             is_setp;
  logic             pred;

  modport master (
    output in_valid, op, a, b, c, out_ready,
    input  in_ready, out_valid, result, ovf, is_setp, pred
  );

  modport slave (
    input  in_valid, op, a, b, c, out_ready,
    output in_ready, out_valid, result, ovf, is_setp, pred
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined lane ALU with valid/ready handshake and an internal predicate register.
// Stage 1 registers the operands and the full-width product; stage 2 finishes the op and updates P.
module alu_pipe #(
  parameter int WIDTH      = 16,
  parameter bit SIGNED_CMP = 1'b0
) (
  input logic     clk,
  input logic     rst_n,
  alu_pipe_if.slave bus
);

  typedef enum logic [3:0] {
    OP_CLEAR = 4'd0,  OP_INC  = 4'd1,  OP_ADD  = 4'd2,  OP_MUL  = 4'd3,
    OP_MAD   = 4'd4,  OP_SEQ  = 4'd5,  OP_SLT  = 4'd6,  OP_SGT  = 4'd7,
    OP_SNE   = 4'd8,  OP_SUB  = 4'd9,  OP_AND  = 4'd10, OP_OR   = 4'd11,
    OP_XOR   = 4'd12, OP_MIN  = 4'd13, OP_MAX  = 4'd14, OP_NOP  = 4'd15
  } op_e;

  logic               adv;
  logic               s1_valid;
  op_e                s1_op;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic [2*WIDTH-1:0] s1_prod;

  logic [WIDTH-1:0]   mul_x;
  logic [WIDTH-1:0]   mul_y;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH:0]     inc_sum;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH:0]   mad_sum;
  logic               lt;
  logic               gt;
  logic [WIDTH-1:0]   nx_result;
  logic               nx_ovf;
  logic               nx_setp;
  logic               nx_cmp;

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // MAD multiplies b*c, MUL multiplies a*b; only one product is ever needed per beat.
  assign mul_x = (bus.op == OP_MAD) ? bus.b : bus.a;
  assign mul_y = (bus.op == OP_MAD) ? bus.c : bus.b;
  assign prod  = {{WIDTH{1'b0}}, mul_x} * {{WIDTH{1'b0}}, mul_y};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_NOP;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_prod  <= '0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s1_op    <= op_e'(bus.op);
      s1_a     <= bus.a;
      s1_b     <= bus.b;
      s1_prod  <= prod;
    end
  end

  assign inc_sum = {1'b0, s1_a} + {{WIDTH{1'b0}}, 1'b1};
  assign add_sum = {1'b0, s1_a} + {1'b0, s1_b};
  assign mad_sum = {{(WIDTH+1){1'b0}}, s1_a} + {1'b0, s1_prod};
  assign lt      = SIGNED_CMP ? ($signed(s1_a) < $signed(s1_b)) : (s1_a < s1_b);
  assign gt      = SIGNED_CMP ? ($signed(s1_a) > $signed(s1_b)) : (s1_a > s1_b);

  always_comb begin
    nx_result = '0;
    nx_ovf    = 1'b0;
    nx_setp   = 1'b0;
    nx_cmp    = 1'b0;
    case (s1_op)
      OP_INC: begin
        nx_result = inc_sum[WIDTH-1:0];
        nx_ovf    = inc_sum[WIDTH];
      end
      OP_ADD: begin
        nx_result = add_sum[WIDTH-1:0];
        nx_ovf    = add_sum[WIDTH];
      end
      OP_MUL: begin
        nx_result = s1_prod[WIDTH-1:0];
        nx_ovf    = |s1_prod[2*WIDTH-1:WIDTH];
      end
      OP_MAD: begin
        nx_result = mad_sum[WIDTH-1:0];
        nx_ovf    = |mad_sum[2*WIDTH:WIDTH];
      end
      OP_SEQ: begin nx_setp = 1'b1; nx_cmp = (s1_a == s1_b); end
      OP_SLT: begin nx_setp = 1'b1; nx_cmp = lt; end
      OP_SGT: begin nx_setp = 1'b1; nx_cmp = gt; end
      OP_SNE: begin nx_setp = 1'b1; nx_cmp = (s1_a != s1_b); end
      OP_SUB: begin
        nx_result = s1_a - s1_b;
        nx_ovf    = (s1_a < s1_b);
      end
      OP_AND:  nx_result = s1_a & s1_b;
      OP_OR:   nx_result = s1_a | s1_b;
      OP_XOR:  nx_result = s1_a ^ s1_b;
      OP_MIN:  nx_result = lt ? s1_a : s1_b;
      OP_MAX:  nx_result = gt ? s1_a : s1_b;
      default: nx_result = '0;
    endcase
  end

  // Bubbles clear out_valid but leave the data fields and P untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.ovf       <= 1'b0;
      bus.is_setp   <= 1'b0;
      bus.pred      <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.result  <= nx_result;
        bus.ovf     <= nx_ovf;
        bus.is_setp <= nx_setp;
        if (nx_setp) bus.pred <= nx_cmp;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: an unsigned-compare and a signed-compare instance share one stimulus stream,
// a queue of model results is checked as beats leave, and each scenario task adds its own checks.
module tb_alu_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b, c;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus_u ();
  alu_pipe_if #(.WIDTH(W)) bus_s ();

  assign bus_u.in_valid  = in_valid;
  assign bus_u.op        = op;
  assign bus_u.a         = a;
  assign bus_u.b         = b;
  assign bus_u.c         = c;
  assign bus_u.out_ready = out_ready;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.op        = op;
  assign bus_s.a         = a;
  assign bus_s.b         = b;
  assign bus_s.c         = c;
  assign bus_s.out_ready = out_ready;

  alu_pipe #(.WIDTH(W), .SIGNED_CMP(1'b0)) u_dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u.slave));
  alu_pipe #(.WIDTH(W), .SIGNED_CMP(1'b1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s.slave));

  typedef struct {
    logic [W-1:0] res_u;
    logic [W-1:0] res_s;
    logic         ovf;
    logic         setp;
    logic         pred_u;
    logic         pred_s;
  } exp_t;

  exp_t sb[$];
  logic mp_u = 1'b0;
  logic mp_s = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] z, input bit sgn, output logic [W-1:0] r,
                                output logic ov, output logic st, output logic cm);
    logic [63:0] full;
    logic        lt, gt;
    r = '0; ov = 1'b0; st = 1'b0; cm = 1'b0; full = '0;
    lt = sgn ? ($signed(x) < $signed(y)) : (x < y);
    gt = sgn ? ($signed(x) > $signed(y)) : (x > y);
    case (o)
      4'd1:  full = 64'(x) + 64'd1;
      4'd2:  full = 64'(x) + 64'(y);
      4'd3:  full = 64'(x) * 64'(y);
      4'd4:  full = 64'(x) + 64'(y) * 64'(z);
      4'd5:  begin st = 1'b1; cm = (x == y); end
      4'd6:  begin st = 1'b1; cm = lt; end
      4'd7:  begin st = 1'b1; cm = gt; end
      4'd8:  begin st = 1'b1; cm = (x != y); end
      4'd9:  begin r = x - y; ov = (x < y); end
      4'd10: r = x & y;
      4'd11: r = x | y;
      4'd12: r = x ^ y;
      4'd13: r = lt ? x : y;
      4'd14: r = gt ? x : y;
      default: r = '0;
    endcase
    if (o >= 4'd1 && o <= 4'd4) begin
      r  = full[W-1:0];
      ov = (full > ((64'd1 << W) - 64'd1));
    end
  endfunction

  // Scoreboard: push on accept, pop and compare on every consumed output beat.
  always @(negedge clk) begin
    exp_t e;
    logic ov2, st2, cu, cs;
    if (rst_n === 1'b1) begin
      if (bus_u.out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_beat: got result=%h with no beat outstanding", bus_u.result);
        end else begin
          e = sb.pop_front();
          if ({bus_u.result, bus_u.ovf, bus_u.is_setp, bus_u.pred} !== {e.res_u, e.ovf, e.setp, e.pred_u}) begin
            n_fail++;
            $display("FAIL sb_unsigned: got res=%h ovf=%b setp=%b pred=%b, want res=%h ovf=%b setp=%b pred=%b",
                     bus_u.result, bus_u.ovf, bus_u.is_setp, bus_u.pred, e.res_u, e.ovf, e.setp, e.pred_u);
          end
          n_checks++;
          if ({bus_s.out_valid, bus_s.result, bus_s.ovf, bus_s.is_setp, bus_s.pred} !== {1'b1, e.res_s, e.ovf, e.setp, e.pred_s}) begin
            n_fail++;
            $display("FAIL sb_signed: got vld=%b res=%h ovf=%b setp=%b pred=%b, want res=%h ovf=%b setp=%b pred=%b",
                     bus_s.out_valid, bus_s.result, bus_s.ovf, bus_s.is_setp, bus_s.pred, e.res_s, e.ovf, e.setp, e.pred_s);
          end
        end
      end
      if (in_valid && bus_u.in_ready) begin
        model(op, a, b, c, 1'b0, e.res_u, e.ovf, e.setp, cu);
        model(op, a, b, c, 1'b1, e.res_s, ov2, st2, cs);
        if (e.setp) begin mp_u = cu; mp_s = cs; end
        e.pred_u = mp_u;
        e.pred_s = mp_s;
        sb.push_back(e);
      end
    end
  end

  task automatic drive(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    in_valid = 1'b1; op = o; a = x; b = y; c = z;
  endtask

  // Issues one beat and returns at the negedge where it should sit in the output register.
  task automatic run_one(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    @(posedge clk); #1 drive(o, x, y, z);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0; c = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus_u.out_valid, bus_u.result, bus_u.ovf, bus_u.is_setp, bus_u.pred, bus_u.in_ready} !== {1'b0, 16'h0, 4'b0001}) begin
      n_fail++;
      $display("FAIL reset_values: got vld=%b res=%h ovf=%b setp=%b pred=%b rdy=%b, want all 0 and rdy=1",
               bus_u.out_valid, bus_u.result, bus_u.ovf, bus_u.is_setp, bus_u.pred, bus_u.in_ready);
    end
    rst_n = 1'b1;
    // Two beats in flight, then reset.
    @(posedge clk); #1 drive(4'd5, 16'd1, 16'd1, 16'd0);
    @(posedge clk); #1 drive(4'd2, 16'd3, 16'd4, 16'd0);
    @(posedge clk); #1 rst_n = 1'b0; in_valid = 1'b0;
    sb.delete(); mp_u = 1'b0; mp_s = 1'b0;
    #1;
    n_checks++;
    if ({bus_u.out_valid, bus_u.result, bus_u.ovf, bus_u.is_setp, bus_u.pred, bus_u.in_ready,
         bus_s.out_valid, bus_s.pred} !== {1'b0, 16'h0, 4'b0001, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_midstream: got vld=%b res=%h ovf=%b setp=%b pred=%b rdy=%b, want all 0 and rdy=1",
               bus_u.out_valid, bus_u.result, bus_u.ovf, bus_u.is_setp, bus_u.pred, bus_u.in_ready);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 drive(4'd1, 16'd7, 16'd0, 16'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_u.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_latency_early: got out_valid=%b after 1 edge, want 0", bus_u.out_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({bus_u.out_valid, bus_u.result} !== {1'b1, 16'd8}) begin
      n_fail++;
      $display("FAIL reset_latency: got vld=%b res=%h after 2 edges, want vld=1 res=0008", bus_u.out_valid, bus_u.result);
    end
    @(negedge clk);
    n_checks++;
    if (bus_u.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_stale: got out_valid=%b, want 0", bus_u.out_valid);
    end
  endtask

  task automatic test_arith();
    logic [3:0]   t_op [4] = '{4'd2, 4'd4, 4'd3, 4'd9};
    logic [W-1:0] t_a  [4] = '{16'hFFFF, 16'd3, 16'h0100, 16'd2};
    logic [W-1:0] t_b  [4] = '{16'h0002, 16'd4, 16'h0100, 16'd5};
    logic [W-1:0] t_c  [4] = '{16'h0000, 16'd5, 16'h0000, 16'd0};
    logic [W-1:0] t_r  [4] = '{16'h0001, 16'd23, 16'h0000, 16'hFFFD};
    logic         t_o  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_one(t_op[i], t_a[i], t_b[i], t_c[i]);
      n_checks++;
      if ({bus_u.out_valid, bus_u.result, bus_u.ovf, bus_u.is_setp} !== {1'b1, t_r[i], t_o[i], 1'b0}) begin
        n_fail++;
        $display("FAIL arith_%0d: got vld=%b res=%h ovf=%b setp=%b, want vld=1 res=%h ovf=%b setp=0",
                 i, bus_u.out_valid, bus_u.result, bus_u.ovf, bus_u.is_setp, t_r[i], t_o[i]);
      end
    end
  endtask

  task automatic test_predicate();
    run_one(4'd5, 16'd5, 16'd5, 16'd0);
    n_checks++;
    if ({bus_u.pred, bus_s.pred, bus_u.is_setp} !== 3'b111) begin
      n_fail++;
      $display("FAIL pred_eq: got pred_u=%b pred_s=%b setp=%b, want 1 1 1", bus_u.pred, bus_s.pred, bus_u.is_setp);
    end
    run_one(4'd6, 16'hFFFF, 16'd1, 16'd0);
    n_checks++;
    if ({bus_u.pred, bus_s.pred, bus_u.is_setp, bus_u.result} !== {3'b011, 16'h0}) begin
      n_fail++;
      $display("FAIL pred_lt: got pred_u=%b pred_s=%b setp=%b res=%h, want 0 1 1 0000",
               bus_u.pred, bus_s.pred, bus_u.is_setp, bus_u.result);
    end
    run_one(4'd2, 16'd1, 16'd1, 16'd0);
    n_checks++;
    if ({bus_u.pred, bus_s.pred, bus_u.is_setp, bus_u.result} !== {3'b010, 16'd2}) begin
      n_fail++;
      $display("FAIL pred_hold_add: got pred_u=%b pred_s=%b setp=%b res=%h, want 0 1 0 0002",
               bus_u.pred, bus_s.pred, bus_u.is_setp, bus_u.result);
    end
  endtask

  task automatic test_throughput();
    logic [3:0]  t_op [8] = '{4'd2, 4'd8, 4'd12, 4'd5, 4'd10, 4'd11, 4'd14, 4'd1};
    logic [11:0] seen = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i < 8) drive(t_op[i], W'($urandom), W'($urandom), W'($urandom));
      else in_valid = 1'b0;
      @(negedge clk);
      seen[i] = bus_u.out_valid;
    end
    n_checks++;
    if (seen !== 12'h3FC) begin
      n_fail++;
      $display("FAIL throughput_valid: got valid pattern=%b, want %b", seen, 12'h3FC);
    end
  endtask

  task automatic test_backpressure();
    int k;
    @(posedge clk); #1 drive(4'd5, 16'd1, 16'd2, 16'd0);
    @(posedge clk); #1 drive(4'd3, 16'd3, 16'd7, 16'd0);
    @(posedge clk); #1 drive(4'd7, 16'd5, 16'd3, 16'd0);
    @(posedge clk); #1 drive(4'd2, 16'd1, 16'd1, 16'd0); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus_u.in_ready, bus_u.out_valid, bus_u.result, bus_u.pred} !== {2'b01, 16'h0015, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_%0d: got rdy=%b vld=%b res=%h pred=%b, want rdy=0 vld=1 res=0015 pred=0",
                 i, bus_u.in_ready, bus_u.out_valid, bus_u.result, bus_u.pred);
      end
      if (i < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus_u.is_setp, bus_u.pred, bus_s.pred} !== 3'b111) begin
      n_fail++;
      $display("FAIL stall_release_setp: got setp=%b pred_u=%b pred_s=%b, want 1 1 1", bus_u.is_setp, bus_u.pred, bus_s.pred);
    end
    k = 0;
    while (sb.size() != 0 && k < 10) begin @(negedge clk); k++; end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL stall_drain: got %0d beats outstanding, want 0", sb.size());
    end
  endtask

  task automatic test_minmax();
    logic pu, ps;
    run_one(4'd13, 16'h8000, 16'h0001, 16'd0);
    n_checks++;
    if ({bus_u.result, bus_s.result} !== {16'h0001, 16'h8000}) begin
      n_fail++;
      $display("FAIL min: got unsigned=%h signed=%h, want 0001 8000", bus_u.result, bus_s.result);
    end
    run_one(4'd14, 16'h8000, 16'h0001, 16'd0);
    n_checks++;
    if ({bus_u.result, bus_s.result} !== {16'h8000, 16'h0001}) begin
      n_fail++;
      $display("FAIL max: got unsigned=%h signed=%h, want 8000 0001", bus_u.result, bus_s.result);
    end
    pu = bus_u.pred; ps = bus_s.pred;
    run_one(4'd15, 16'h1234, 16'h5678, 16'd0);
    n_checks++;
    if ({bus_u.out_valid, bus_u.result, bus_u.ovf, bus_u.pred, bus_s.pred} !== {1'b1, 16'h0, 1'b0, pu, ps}) begin
      n_fail++;
      $display("FAIL nop: got vld=%b res=%h ovf=%b pred_u=%b pred_s=%b, want 1 0000 0 %b %b",
               bus_u.out_valid, bus_u.result, bus_u.ovf, bus_u.pred, bus_s.pred, pu, ps);
    end
    run_one(4'd0, 16'hFFFF, 16'hFFFF, 16'd0);
    n_checks++;
    if ({bus_u.out_valid, bus_u.result, bus_u.ovf, bus_u.pred, bus_s.pred} !== {1'b1, 16'h0, 1'b0, pu, ps}) begin
      n_fail++;
      $display("FAIL clear: got vld=%b res=%h ovf=%b pred_u=%b pred_s=%b, want 1 0000 0 %b %b",
               bus_u.out_valid, bus_u.result, bus_u.ovf, bus_u.pred, bus_s.pred, pu, ps);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_predicate();
    test_throughput();
    test_backpressure();
    test_minmax();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
